// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory initiator
package mem_pkg;

    // Bus-master sequencing: arbitrate, access the memory, acknowledge
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Which requester owns the transfer in flight
    typedef enum logic {
        SRC_FETCH,
        SRC_DATA
    } src_t;

    // Number of valid words in the shared memory
    localparam int MEM_DEPTH_DEFAULT = 129;

endpackage

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - arbitrating bus master for the shared word-addressed memory
import mem_pkg::*;

module mem_initiator #(
    parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    output logic        fetch_ack,
    output logic [31:0] instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        fault,
    output logic [31:0] Address,
    output logic [31:0] w_data,
    output logic        we,
    output logic        re,
    input  logic [31:0] mem_data
);

    // Range limit compared against the full 32-bit address
    localparam logic [31:0] DEPTH_W   = 32'(MEM_DEPTH);
    // Wait counter load value; counts down to zero in the final ACCESS cycle
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    src_t        src, src_n;
    logic        dir_we, dir_we_n;
    logic        in_rng, in_rng_n;
    logic [31:0] address_n;
    logic [31:0] w_data_n;
    logic        last;
    logic        re_n;
    logic        we_n;
    logic        fetch_ack_n;
    logic        data_ack_n;
    logic        fault_n;

    // Next-state logic, request latching, and next values of the registered pins
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        src_n     = src;
        dir_we_n  = dir_we;
        in_rng_n  = in_rng;
        address_n = Address;
        w_data_n  = w_data;
        case (state)
            IDLE: begin
                if (data_req) begin
                    src_n     = SRC_DATA;
                    dir_we_n  = data_we;
                    address_n = data_addr;
                    w_data_n  = data_wdata;
                    in_rng_n  = (data_addr < DEPTH_W);
                    cnt_n     = WAIT_INIT;
                    state_n   = ACCESS;
                end else if (fetch_req) begin
                    src_n     = SRC_FETCH;
                    dir_we_n  = 1'b0;
                    address_n = pc;
                    in_rng_n  = (pc < DEPTH_W);
                    cnt_n     = WAIT_INIT;
                    state_n   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Final ACCESS cycle: read data is captured and the ack is launched
        last        = (state == ACCESS) && (cnt == 4'd0);
        // Pins are computed from the next state so they come straight out of flops
        re_n        = (state_n == ACCESS) && !dir_we_n && in_rng_n;
        we_n        = (state_n == ACCESS) && (cnt_n == 4'd0) && dir_we_n && in_rng_n;
        fetch_ack_n = last && (src == SRC_FETCH);
        data_ack_n  = last && (src == SRC_DATA);
        fault_n     = last && !in_rng;
    end

    // FSM state register and latched transfer attributes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            src    <= SRC_FETCH;
            dir_we <= 1'b0;
            in_rng <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            src    <= src_n;
            dir_we <= dir_we_n;
            in_rng <= in_rng_n;
        end
    end

    // Registered memory pins and requester handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Address   <= 32'd0;
            w_data    <= 32'd0;
            re        <= 1'b0;
            we        <= 1'b0;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            Address   <= address_n;
            w_data    <= w_data_n;
            re        <= re_n;
            we        <= we_n;
            fetch_ack <= fetch_ack_n;
            data_ack  <= data_ack_n;
            fault     <= fault_n;
        end
    end

    // Read result capture; out-of-range reads return zero, stores leave results alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr      <= 32'd0;
            data_rdata <= 32'd0;
        end else if (last && !dir_we) begin
            if (src == SRC_DATA) begin
                data_rdata <= in_rng ? mem_data : 32'd0;
            end else begin
                instr <= in_rng ? mem_data : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - scoreboard bench for mem_initiator with behavioural memory model
module tb_mem_initiator;
    import mem_pkg::*;

    localparam int          DEPTH   = 129;
    localparam logic [31:0] DEPTH_W = 32'd129;
    localparam int          W0      = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // DUT with no wait states
    logic        fetch_req = 0, data_req = 0, data_we = 0;
    logic [31:0] pc = 0, data_addr = 0, data_wdata = 0;
    logic        fetch_ack, data_ack, fault, we, re;
    logic [31:0] instr, data_rdata, Address, w_data, mem_data;

    // DUT with three wait states
    logic        f3_req = 0, d3_req = 0, d3_we = 0;
    logic [31:0] pc3 = 0, d3_addr = 0, d3_wdata = 0;
    logic        f3_ack, d3_ack, fault3, we3, re3;
    logic [31:0] instr3, d3_rdata, addr3, w_data3, mem_data3;

    logic [31:0] sim_mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    mem_initiator #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .pc(pc), .fetch_ack(fetch_ack), .instr(instr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .fault(fault),
        .Address(Address), .w_data(w_data), .we(we), .re(re), .mem_data(mem_data)
    );

    mem_initiator #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(f3_req), .pc(pc3), .fetch_ack(f3_ack), .instr(instr3),
        .data_req(d3_req), .data_we(d3_we), .data_addr(d3_addr), .data_wdata(d3_wdata),
        .data_ack(d3_ack), .data_rdata(d3_rdata), .fault(fault3),
        .Address(addr3), .w_data(w_data3), .we(we3), .re(re3), .mem_data(mem_data3)
    );

    // Responder memory: combinational read while re, write on the edge while we
    assign mem_data  = (re && Address < DEPTH_W) ? sim_mem[Address[7:0]] : 32'hBAD0_BAD0;
    assign mem_data3 = (re3 && addr3 < DEPTH_W) ? sim_mem[addr3[7:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (we && Address < DEPTH_W) sim_mem[Address[7:0]] <= w_data;
    end

    typedef struct {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        flt;
        int          ack_cyc;
    } exp_t;

    exp_t exp_f_q[$];
    exp_t exp_d_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: one word-addressed array, out-of-range accesses fault and read 0
    function automatic exp_t model(input logic st, input logic [31:0] a, input logic [31:0] wd,
                                   input int ack_cyc);
        exp_t e;
        e.is_store = st;
        e.addr     = a;
        e.wdata    = wd;
        e.ack_cyc  = ack_cyc;
        e.flt      = (a >= DEPTH_W);
        e.rdata    = 32'd0;
        if (!e.flt) begin
            if (st) ref_mem[a[7:0]] = wd;
            else    e.rdata = ref_mem[a[7:0]];
        end
        return e;
    endfunction

    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] we_a = 0;
    logic [31:0] we_d = 0;

    task automatic score(input string nm, input exp_t e, input logic [31:0] got);
        check({nm, "_ack_cycle"}, cyc, e.ack_cyc);
        check({nm, "_fault"}, {31'd0, fault}, {31'd0, e.flt});
        if (!e.is_store) check({nm, "_rdata"}, got, e.rdata);
        check({nm, "_re_cycles"}, re_cnt, (!e.is_store && !e.flt) ? W0 + 1 : 0);
        check({nm, "_we_pulses"}, we_cnt, (e.is_store && !e.flt) ? 1 : 0);
        if (e.is_store && !e.flt) begin
            check({nm, "_we_addr"}, we_a, e.addr);
            check({nm, "_we_data"}, we_d, e.wdata);
        end
    endtask

    // Monitor: watches the memory pins and pops the scoreboard on every ack
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            if (re || we) check("re_we_exclusive", {31'd0, re & we}, 32'd0);
            if (re) re_cnt++;
            if (we) begin
                we_cnt++;
                we_a = Address;
                we_d = w_data;
            end
            if (fault && !data_ack && !fetch_ack) check("stray_fault", 32'd1, 32'd0);
            if (data_ack) begin
                if (exp_d_q.size() == 0) check("data_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_d_q.pop_front();
                    score("data", e, data_rdata);
                end
                re_cnt = 0;
                we_cnt = 0;
            end
            if (fetch_ack) begin
                if (exp_f_q.size() == 0) check("fetch_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_f_q.pop_front();
                    score("fetch", e, instr);
                end
                re_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    // Requester side: hold each request until its ack, bounded by a cycle budget
    task automatic wait_acks(input bit wf, input bit wd);
        int n;
        n = 0;
        while ((wf || wd) && n < 60) begin
            @(negedge clk);
            n++;
            if (fetch_ack) begin fetch_req = 0; wf = 0; end
            if (data_ack)  begin data_req = 0;  wd = 0; end
        end
        if (wf || wd) begin
            check("ack_timeout", 32'd1, 32'd0);
            fetch_req = 0;
            data_req  = 0;
            exp_f_q.delete();
            exp_d_q.delete();
        end
    endtask

    task automatic issue(input bit do_f, input logic [31:0] f_addr, input bit do_d,
                         input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wd);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        // data wins arbitration, so its effect on memory precedes the fetch
        if (do_d) begin
            data_req   = 1;
            data_we    = d_we;
            data_addr  = d_addr;
            data_wdata = d_wd;
            exp_d_q.push_back(model(d_we, d_addr, d_wd, c + 2 + W0));
        end
        if (do_f) begin
            fetch_req = 1;
            pc        = f_addr;
            exp_f_q.push_back(model(1'b0, f_addr, 32'd0, do_d ? c + 5 + 2 * W0 : c + 2 + W0));
        end
        wait_acks(do_f, do_d);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'd129;
            1:       a = 32'h8000_0010;
            2:       a = $urandom | 32'h0000_0100;
            default: a = 32'($urandom_range(0, DEPTH - 1));
        endcase
        return a;
    endfunction

    task automatic mem_compare(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (sim_mem[i] !== ref_mem[i]) bad++;
        check(nm, bad, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        int n3;
        int kind;
        for (int i = 0; i < DEPTH; i++) sim_mem[i] = $urandom;
        sim_mem[64] = 32'h2011_0000;
        sim_mem[65] = 32'h2008_0002;
        sim_mem[24] = 32'h0000_0010;
        sim_mem[25] = 32'h0000_0001;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = sim_mem[i];

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {fetch_ack, data_ack, fault, we, re}, 32'd0);
        check("reset_buses", instr | data_rdata | Address | w_data, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // directed sequence from the test plan
        issue(1, 32'd64, 0, 0, 32'd0, 32'd0);
        issue(0, 32'd0, 1, 0, 32'd24, 32'd0);
        issue(0, 32'd0, 1, 1, 32'd30, 32'hDEAD_BEEF);
        issue(0, 32'd0, 1, 0, 32'd30, 32'd0);
        issue(1, 32'd65, 1, 0, 32'd25, 32'd0);
        issue(0, 32'd0, 1, 1, 32'd200, 32'h1234_5678);
        mem_compare("mem_after_oob_store");

        // reset during the ACCESS cycle of a store
        @(posedge clk);
        #1;
        data_req   = 1;
        data_we    = 1;
        data_addr  = 32'd30;
        data_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("midreset_pins", {fetch_ack, data_ack, fault, we, re}, 32'd0);
        check("midreset_buses", instr | data_rdata | Address | w_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_write", sim_mem[30], 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1;
        c = cyc;
        exp_d_q.push_back(model(1'b1, 32'd30, 32'hCAFE_F00D, c + 2 + W0));
        wait_acks(0, 1);
        issue(0, 32'd0, 1, 0, 32'd30, 32'd0);

        // wait-state instance: load from 24
        @(posedge clk);
        #1;
        d3_req  = 1;
        d3_we   = 0;
        d3_addr = 32'd24;
        c       = cyc;
        n3      = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (re3) n3++;
            if (d3_ack) break;
        end
        check("w3_ack_seen", {31'd0, d3_ack}, 32'd1);
        check("w3_latency", cyc - c, 32'd5);
        check("w3_re_cycles", n3, 32'd4);
        check("w3_rdata", d3_rdata, 32'h0000_0010);
        check("w3_fault", {31'd0, fault3}, 32'd0);
        d3_req = 0;

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            kind = $urandom_range(0, 2);
            issue(kind != 1, rand_addr(), kind != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        repeat (3) @(posedge clk);
        check("queues_drained", exp_f_q.size() + exp_d_q.size(), 32'd0);
        mem_compare("mem_final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus master for the multicycle datapath's shared word-addressed memory. It arbitrates instruction-fetch and load/store requests from the control unit and drives the memory's `Address`/`w_data`/`we`/`re` pins. It captures `mem_data` on reads and returns a one-cycle acknowledge to the winning requester. The memory is the responder: combinational read while `re` is high, write on the clock edge while `we` is high.

## Interface
- `MEM_DEPTH`, 129: number of valid words; addresses `>= MEM_DEPTH` are faults.
- `WAIT_CYCLES`, 0: extra ACCESS cycles inserted before capture or write, range 0–15.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: **one clock; reset is asynchronous and active-low.**
- `fetch_req` in 1: instruction fetch request; held until `fetch_ack`.
- `pc` in 32: fetch word address.
- `fetch_ack` out 1: one-cycle pulse; `instr` is valid in that cycle.
- `instr` out 32: fetched word.
- `data_req` in 1: load/store request; held until `data_ack`.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in 32: load/store word address.
- `data_wdata` in 32: store data.
- `data_ack` out 1: one-cycle pulse.
- `data_rdata` out 32: load result, valid with `data_ack`.
- `fault` out 1: pulses with the ack when the address was out of range.
- `Address` out 32: memory address.
- `w_data` out 32: memory write data.
- `we` out 1: memory write enable.
- `re` out 1: memory read enable.
- `mem_data` in 32: memory read data.

## Operation
- FSM states and transitions:
  - IDLE: arbitrates. A `data_req` wins over a `fetch_req` (fixed priority). It latches address, direction, write data and source, then goes to ACCESS. With no request it stays in IDLE.
  - ACCESS: drives `Address` from the latched address. Reads hold `re=1` for all `WAIT_CYCLES+1` ACCESS cycles. In the final cycle, a read captures `mem_data` into the source's result register; a write asserts `we=1` for that cycle only. Then it goes to DONE.
  - DONE: pulses the source's ack, then returns to IDLE.
- Out-of-range address (`>= MEM_DEPTH`):
  - ACCESS keeps `re`/`we` low.
  - The result register loads 0.
  - `fault` pulses with the ack.
- Handshake rules:
  - Requester keeps req, address and data stable until its ack.
  - req high in the cycle after ack is a new request.
  - A losing request stays pending and is served on the next IDLE visit.
- `instr`/`data_rdata` hold their last value until the next completed read from the same source. Stores do not change `data_rdata`.
- Address decode uses the full 32 bits for the range check. `Address` is passed through unchanged.

## Timing
- Reset values: state IDLE; `fetch_ack`, `data_ack`, `fault`, `we`, `re` = 0; `instr`, `data_rdata`, `Address`, `w_data` = 0.
- All outputs are registered, with no combinational path from req to memory pins.
- Latency is `2+WAIT_CYCLES` cycles, from the IDLE cycle that samples the request to the ack cycle.
- Back-to-back accesses:
  - The minimum gap between successive acks is `3+WAIT_CYCLES` cycles.
  - With simultaneous requests, the fetch ack comes `3+WAIT_CYCLES` cycles after the data ack.
- `we` is high for exactly one cycle per in-range store; `re` is never high in the same cycle as `we`.
- Reset mid-operation: the FSM returns to IDLE immediately, with no `we` pulse, no ack and no fault. Pending requests are re-arbitrated after `rst_n` rises.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum `{IDLE, ACCESS, DONE}`;
  - the source enum `{SRC_FETCH, SRC_DATA}`;
  - the default `MEM_DEPTH` constant.
- Single module; the wait counter is a 4-bit down-counter inside the FSM. No sub-module.

## Test plan
- Fetch with memory preloaded, `WAIT_CYCLES=0`: `fetch_req` with `pc=64` → `re` high for 1 cycle, `fetch_ack` 2 cycles after sampling, `instr=32'h20110000`, `fault=0`.
- Load: `data_addr=24` → `data_rdata=32'h00000010`. With `WAIT_CYCLES=3`, the ack arrives 5 cycles after sampling and `re` is high for 4 cycles.
- Store then load: `data_addr=30`, `data_wdata=32'hDEADBEEF` → one `we` pulse with `Address=30`, `data_ack`. A subsequent load from 30 returns `32'hDEADBEEF`.
- Simultaneous `fetch_req`(`pc=65`) and `data_req`(load addr 25):
  - `data_ack` comes first, with `data_rdata=1`.
  - `fetch_ack` follows 3 cycles later, with `instr=32'h20080002`.
- Out-of-range store to addr 200 → `we` never asserts; `data_ack` and `fault` pulse together. The memory at addresses 0–128 is unchanged.
- `rst_n` low during the ACCESS cycle of a store → no `we` pulse and no ack, and all outputs are 0. After release, the held request completes normally.
